// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multi-cycle multiply/divide unit with private HI/LO registers
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  logic [63:0] mul_s, mul_u;
  logic [31:0] abs_a, abs_b, div_b_s, div_b_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        div_zero;

  assign mul_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign mul_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  // A zero divisor is replaced by 1 only to keep the datapath defined; that result is discarded.
  assign div_zero = (rt_val == 32'd0);
  assign abs_a    = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign abs_b    = rt_val[31] ? (32'd0 - rt_val) : rt_val;
  assign div_b_s  = div_zero ? 32'd1 : abs_b;
  assign div_b_u  = div_zero ? 32'd1 : rt_val;
  assign q_mag    = abs_a / div_b_s;
  assign r_mag    = abs_a % div_b_s;
  assign q_s      = (rs_val[31] ^ rt_val[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s      = rs_val[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u      = rs_val / div_b_u;
  assign r_u      = rs_val % div_b_u;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              state_d   = BUSY;
              cnt_d     = CNT_W'(MULT_CYCLES);
              pend_hi_d = (op == 3'd0) ? mul_s[63:32] : mul_u[63:32];
              pend_lo_d = (op == 3'd0) ? mul_s[31:0]  : mul_u[31:0];
              pend_wr_d = 1'b1;
            end
            3'd2, 3'd3: begin
              state_d   = BUSY;
              cnt_d     = CNT_W'(DIV_CYCLES);
              pend_hi_d = (op == 3'd2) ? r_s : r_u;
              pend_lo_d = (op == 3'd2) ? q_s : q_u;
              pend_wr_d = !div_zero;
            end
            3'd4:    hi_d = rs_val;
            3'd5:    lo_d = rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign stall_req = busy | (start & ~op[2]);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized and directed checks of md_unit against a transaction-level model
module tb_md_unit;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int n_pass = 0;
  int n_total = 0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Model: an accepted op is a pending result that lands after N clock edges.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;
  bit          m_wr;

  always @(posedge clk or negedge reset) begin
    longint a, b, q, r;
    logic [63:0] prod;
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_wr = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_wr) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (start) begin
      case (op)
        3'd0, 3'd1: begin
          if (op == 3'd0) begin
            a = longint'($signed(rs_val)); b = longint'($signed(rt_val));
            prod = 64'(a * b);
          end else begin
            prod = {32'd0, rs_val} * {32'd0, rt_val};
          end
          p_hi = prod[63:32]; p_lo = prod[31:0]; m_wr = 1; m_left = MULT_N;
        end
        3'd2, 3'd3: begin
          m_left = DIV_N;
          m_wr = (rt_val != 0);
          if (m_wr) begin
            if (op == 3'd2) begin
              a = longint'($signed(rs_val)); b = longint'($signed(rt_val));
            end else begin
              a = longint'({32'd0, rs_val}); b = longint'({32'd0, rt_val});
            end
            q = a / b; r = a % b;
            p_lo = q[31:0]; p_hi = r[31:0];
          end
        end
        3'd4: m_hi = rs_val;
        3'd5: m_lo = rs_val;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check("stall_req", {31'd0, stall_req}, {31'd0, (m_left > 0) || (start && op <= 3'd3)});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); rs_val = $urandom; rt_val = $urandom;
  endtask

  // Called just after the start edge; verifies busy is high for exactly n cycles.
  task automatic wait_done(input int n);
    check("busy_first", {31'd0, busy}, 32'd1);
    repeat (n - 1) @(posedge clk);
    #1 check("busy_last", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("busy_fall", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_left > 0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("idle_timeout", {31'd0, m_left > 0}, 32'd0);
  endtask

  initial begin
    #12;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    issue(3'd0, 32'hFFFF_FFFF, 32'd2); wait_done(MULT_N);
    check("mult_hi", hi, 32'hFFFF_FFFF); check("mult_lo", lo, 32'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2); wait_done(MULT_N);
    check("multu_hi", hi, 32'h0000_0001); check("multu_lo", lo, 32'hFFFF_FFFE);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2); wait_done(DIV_N);
    check("div_lo", lo, 32'hFFFF_FFFD); check("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd2); wait_done(DIV_N);
    check("divu_lo", lo, 32'd3); check("divu_hi", hi, 32'd1);
    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi", hi, 32'h1234_5678);
    issue(3'd3, 32'd5, 32'd0); wait_done(DIV_N);
    check("div0_hi", hi, 32'h1234_5678); check("div0_lo", lo, 32'd3);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(DIV_N);
    check("divovf_lo", lo, 32'h8000_0000); check("divovf_hi", hi, 32'd0);

    issue(3'd0, 32'h10, 32'h20);
    start = 1'b1; op = 3'd5; rs_val = 32'hDEAD;
    @(posedge clk); #1;
    op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (MULT_N - 3) @(posedge clk);
    #1 check("ign_busy_last", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("ign_busy_fall", {31'd0, busy}, 32'd0);
    check("ign_lo", lo, 32'h200); check("ign_hi", hi, 32'd0);

    issue(3'd4, 32'hCAFE_0001, 32'd0);
    issue(3'd2, 32'd50, 32'd3);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0; #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0); check("arst_lo", lo, 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    issue(3'd1, 32'd3, 32'd4); wait_done(MULT_N);
    check("post_lo", lo, 32'd12); check("post_hi", hi, 32'd0);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 9) < 4);
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin rs_val = 32'h8000_0000; rt_val = 32'hFFFF_FFFF; end
        1: begin rs_val = $urandom; rt_val = 32'd0; end
        2: begin rs_val = $urandom_range(0, 20); rt_val = $urandom_range(1, 5); end
        default: begin rs_val = $urandom; rt_val = $urandom; end
      endcase
    end
    start = 1'b0;
    wait_idle();
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
